edge_capture_pipe: RTL
======================

// Module: edge_capture_pipe
// PURPOSE
//   Multi-channel sampled-input front end. Registers CH asynchronous-style stimulus bits through a
//   DEPTH-stage pipeline, detects rise/fall/both edges per channel, and counts the edges in saturating counters.
//   An arm/hit FSM per channel time-stamps the first edge after arming against a free-running counter.
//   Used in small-circuit benches and designs as a deterministic edge monitor, with all updates on clk only.
// PARAMETERS
//   CH     4   number of channels (>=1)
//   DEPTH  2   input-to-dly_out latency in cycles (>=1)
//   CNT_W  8   per-channel edge counter width, saturating
//   TS_W   16  timestamp counter width, wraps
// PORTS
//   clk       in   1         clock, all state updates on rising edge
//   rst_n     in   1         synchronous reset, active low
//   en        in   1         1: edge detect/count/capture enabled; pipeline and ts always run
//   mode      in   2         00 none, 01 rising, 10 falling, 11 both
//   din       in   CH        raw channel inputs
//   arm       in   CH        per-channel arm request (level sampled each cycle)
//   clr       in   CH        per-channel clear: counter->0, FSM->IDLE, first_ts->0
//   dly_out   out  CH        din delayed DEPTH cycles
//   edge_pls  out  CH        1-cycle edge indication, aligned with dly_out
//   any_edge  out  1         OR of edge_pls
//   edge_cnt  out  CH*CNT_W  edge counters, ch0 in LSBs
//   armed     out  CH        FSM in ARMED
//   hit       out  CH        FSM in HIT
//   first_ts  out  CH*TS_W   ts value at first edge after arming, ch0 in LSBs
//   ts        out  TS_W      free-running timestamp
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): pipeline, counters, ts, first_ts all 0; FSMs IDLE; all outputs 0.
// - Pipeline: s[0]<=din, s[k]<=s[k-1], plus prev<=s[DEPTH-1]; dly_out=s[DEPTH-1] (latency DEPTH).
// - Edge: rise = s[DEPTH-1]&~prev, fall = ~s[DEPTH-1]&prev; edge_pls = en & mode-select (combinational
//   from registers only). After reset prev=0, so a 1 held on din gives exactly one rising edge.
// - mode/en changes act in the same cycle on edge_pls; the pipeline keeps shifting when en=0 (edges
//   passing while en=0 are lost, never replayed).
// - Counter: at a posedge with edge_pls[i]=1, cnt[i]<=cnt[i]+1; it holds at 2^CNT_W-1 (no wrap).
//   The new value is visible the cycle after the pulse.
// - ts: increments every cycle after reset, wraps from 2^TS_W-1 to 0; unaffected by en/clr.
// - FSM per channel: IDLE -arm-> ARMED -edge_pls-> HIT; HIT -clr-> IDLE; ARMED -clr-> IDLE.
//   * On the ARMED->HIT edge, first_ts[i]<=ts in the same cycle as edge_pls.
//   * arm in ARMED or HIT is ignored; HIT is held until clr.
//   * Priority: clr > arm > edge. clr with edge_pls gives cnt=0, and that edge is not counted.
//   * arm in IDLE in the same cycle as an edge: go to ARMED, and this edge is not captured.
// - Channels are fully independent; no cross-channel interaction except any_edge.
// - Reset asserted mid-operation clears everything at the next posedge regardless of other inputs.
// TESTING (CH=4, DEPTH=2, CNT_W=4, TS_W=8)
// 1 Reset, then din=4'b0001 at cycle 0 -> dly_out[0]=1 and edge_pls[0]=1 at cycle 2 only, edge_cnt ch0=1 at cycle 3.
// 2 mode=11, toggle din[1] every cycle for 20 cycles -> edge_cnt ch1 saturates at 15 and stays 15.
// 3 arm[2] at ts=5, din[2] rises such that edge_pls[2] at ts=9 -> hit[2]=1, first_ts ch2=9; later edges leave
//   first_ts unchanged, and further arms are ignored.
// 4 clr[3] in the same cycle as edge_pls[3], with cnt=3 -> cnt=0 and FSM IDLE next cycle; arm+clr together -> IDLE.
// 5 en=0 while din[0] rises, then en=1 -> no pulse and no count; mode=10 then counts only the falling edge.
// 6 Run for 256 cycles -> ts wraps 255->0; rst_n=0 for one cycle mid-run -> all outputs 0 at the next cycle.

Source files
------------

// File: rtl/edge_capture_pipe.sv
// Multi-channel edge monitor: DEPTH-stage input pipeline, per-channel edge detect,
// saturating edge counters and an arm/hit timestamp capture against a free-running ts.

module edge_capture_lane #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic             arm,
  input  logic             clr,
  input  logic [TS_W-1:0]  ts,
  output logic             dly_out,
  output logic             edge_pls,
  output logic [CNT_W-1:0] cnt,
  output logic             armed,
  output logic             hit,
  output logic [TS_W-1:0]  first_ts
);
  typedef enum logic [1:0] {IDLE, ARMED, HIT} state_e;

  logic [DEPTH-1:0] s_q, s_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TS_W-1:0]  first_ts_q, first_ts_d;
  state_e           state_q, state_d;
  logic             rise, fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q        <= '0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      first_ts_q <= '0;
      state_q    <= IDLE;
    end else begin
      s_q        <= s_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      first_ts_q <= first_ts_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    s_d    = s_q;
    s_d[0] = din;
    for (int k = 1; k < DEPTH; k++) s_d[k] = s_q[k-1];
    prev_d = s_q[DEPTH-1];

    rise     = s_q[DEPTH-1] & ~prev_q;
    fall     = ~s_q[DEPTH-1] & prev_q;
    edge_pls = en & ((mode[0] & rise) | (mode[1] & fall));

    // clr wins over a coincident edge, so that edge is never counted
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (edge_pls && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;

    state_d    = state_q;
    first_ts_d = first_ts_q;
    if (clr) begin
      state_d    = IDLE;
      first_ts_d = '0;
    end else begin
      case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED:   if (edge_pls) begin
                   state_d    = HIT;
                   first_ts_d = ts;
                 end
        default: ;
      endcase
    end
  end

  assign dly_out  = s_q[DEPTH-1];
  assign cnt      = cnt_q;
  assign armed    = (state_q == ARMED);
  assign hit      = (state_q == HIT);
  assign first_ts = first_ts_q;
endmodule

module edge_capture_pipe #(
  parameter int CH    = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [CH-1:0]       din,
  input  logic [CH-1:0]       arm,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       dly_out,
  output logic [CH-1:0]       edge_pls,
  output logic                any_edge,
  output logic [CH*CNT_W-1:0] edge_cnt,
  output logic [CH-1:0]       armed,
  output logic [CH-1:0]       hit,
  output logic [CH*TS_W-1:0]  first_ts,
  output logic [TS_W-1:0]     ts
);
  logic [TS_W-1:0]            ts_q, ts_d;
  logic [CH-1:0][CNT_W-1:0]   cnt_w;
  logic [CH-1:0][TS_W-1:0]    fts_w;

  always_ff @(posedge clk) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  always_comb begin
    ts_d = ts_q + 1'b1;
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    edge_capture_lane #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .din      (din[i]),
      .arm      (arm[i]),
      .clr      (clr[i]),
      .ts       (ts_q),
      .dly_out  (dly_out[i]),
      .edge_pls (edge_pls[i]),
      .cnt      (cnt_w[i]),
      .armed    (armed[i]),
      .hit      (hit[i]),
      .first_ts (fts_w[i])
    );
  end

  assign any_edge = |edge_pls;
  assign edge_cnt = cnt_w;
  assign first_ts = fts_w;
  assign ts       = ts_q;
endmodule
